ib_mul_8x8_qs: RTL and testbench
================================

Name: ib_mul_8x8_qs

Overview:
- Registered 8x8 unsigned multiplier producing a full 16-bit product, built on the quarter-square identity (qs); "l0" denotes the base, single-register variant.
- Used as a benchmark arithmetic block in the ib_mul family.
- Accepts one operand pair per clock; the product appears at a registered output.

Parameters:
- None. Widths are fixed: operands 8 bits, product 16 bits.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_nrst  input  1  reset, asynchronous, active-low.
- i_vld  input  1  operand pair on i_a/i_b is valid this cycle.
- i_a  input  8  multiplicand, unsigned.
- i_b  input  8  multiplier, unsigned.
- o_vld  output  1  o_c holds a fresh product.
- o_c  output  16  product i_a*i_b, unsigned, registered.

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-low.
- Reset (i_nrst=0): o_c=16'h0000 and o_vld=0 immediately, independent of i_clk; both hold until the first rising edge after release.
- Arithmetic, unsigned, exact over all 65536 operand pairs:
  - s = i_a + i_b, 9 bits (0..510).
  - d = |i_a - i_b|, 8 bits (0..255).
  - o_c = floor(s^2/4) - floor(d^2/4).
  - The subtraction is exact because s and d share parity. The result never underflows and never exceeds 65025 (16'hFE01).
- Square terms:
  - Implemented as quarter-square lookup (case ROM or generated logic); choice is open.
  - The design must not infer a generic a*b multiplier.
  - Quarter-square range: s-term 0..65025 (16 bits); d-term 0..16256 (14 bits).
- Latency: 1 cycle. On each rising edge with i_vld=1, o_c <= product of the current i_a/i_b, and o_vld <= 1.
- i_vld=0 at an edge: o_vld <= 0; o_c holds its previous value.
- Throughput: one product per cycle; back-to-back valid pairs yield back-to-back results with no bubbles.
- No backpressure; o_vld is a single-cycle strobe per accepted pair.
- Operand changes between edges have no effect; inputs are sampled only at the rising edge.
- Reset asserted mid-stream: any in-flight result is discarded; o_vld=0 and o_c=0 asynchronously.

Optional Feature:
- Macro IB_MUL_8X8_QS_PIPE_EN.
- Defined:
  - An extra register stage is inserted after the two quarter-square lookups (before the subtraction).
  - Latency becomes 2 cycles; throughput stays 1/cycle.
  - o_vld is delayed to match the data.
  - The extra stage also resets asynchronously to 0.
- Undefined: latency 1 as above.
- Product values are identical in both builds.

Test Plan:
- Reset: hold i_nrst=0 with i_a=8'hFF, i_b=8'hFF, then release with i_vld=0 -> o_c=0, o_vld=0 throughout.
- Corner values, i_vld=1:
  - 0*0 -> 0.
  - 255*255 -> 65025.
  - 1*255 -> 255.
  - 128*2 -> 256.
  - 255*0 -> 0.
  - Each result appears one cycle later (two with IB_MUL_8X8_QS_PIPE_EN) with o_vld=1.
- Exhaustive: sweep i_a 0..255 x i_b 0..255 back-to-back with i_vld=1 -> every o_c equals i_a*i_b, o_vld continuous, zero mismatches.
- Valid gating:
  - Sequence vld=1 (3*5), vld=0 (9*9), vld=1 (7*11) -> outputs 15 (vld=1), 15 held (vld=0), 77 (vld=1).
- Reset mid-stream: pulse i_nrst low between clock edges during streaming of 200*200 -> o_c drops to 0 and o_vld to 0 immediately; the next valid pair after release yields its correct product.
- Symmetry/parity: a=17,b=4 and a=4,b=17 -> both 68; a=254,b=1 -> 254.

Source files
------------

// File: rtl/ib_mul_8x8_qs.sv
// ---------------------------------------------------------------------------
// ib_mul_8x8_qs
//   Registered 8x8 unsigned multiplier built on the quarter-square identity:
//     a*b = floor((a+b)^2/4) - floor((a-b)^2/4)
//   Both quarter-square terms come from constant lookup tables. The tables
//   are elaborated from genvar constants, so no run-time multiplier exists.
//
//   Optional build macro: IB_MUL_8X8_QS_PIPE_EN
//     undefined : 1-cycle latency (lookups + subtract feed the output flop)
//     defined   : 2-cycle latency, an extra register stage holds the two
//                 lookup results ahead of the subtraction.
//   Product values are identical in both builds.
//
// Ports
//   i_clk   in   1   clock, rising edge
//   i_nrst  in   1   asynchronous active-low reset
//   i_vld   in   1   operand pair valid this cycle
//   i_a     in   8   multiplicand, unsigned
//   i_b     in   8   multiplier, unsigned
//   o_vld   out  1   single-cycle strobe: o_c holds a fresh product
//   o_c     out  16  registered product; holds its value while o_vld=0
// ---------------------------------------------------------------------------
module ib_mul_8x8_qs (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_vld,
    input  logic [7:0]  i_a,
    input  logic [7:0]  i_b,
    output logic        o_vld,
    output logic [15:0] o_c
);

    // -----------------------------------------------------------------------
    // Sum and absolute difference. Sum and difference always share parity,
    // which is what makes the difference of floored quarter-squares exact.
    // -----------------------------------------------------------------------
    logic [8:0] sum;
    logic [7:0] diff;

    always_comb begin
        sum  = {1'b0, i_a} + {1'b0, i_b};
        diff = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
    end

    // -----------------------------------------------------------------------
    // Quarter-square tables. Entries are constants computed from the genvar
    // at elaboration. The sum table is padded to 512 entries so the 9-bit
    // index covers the whole array; entry 511 is unreachable (max sum 510).
    // -----------------------------------------------------------------------
    logic [15:0] qs_s_rom [512];
    logic [13:0] qs_d_rom [256];

    for (genvar k = 0; k < 512; k++) begin : g_qs_s
        assign qs_s_rom[k] = 16'((k * k) >> 2);
    end

    for (genvar k = 0; k < 256; k++) begin : g_qs_d
        assign qs_d_rom[k] = 14'((k * k) >> 2);
    end

    logic [15:0] qs_s;
    logic [13:0] qs_d;

    always_comb begin
        qs_s = qs_s_rom[sum];
        qs_d = qs_d_rom[diff];
    end

    // -----------------------------------------------------------------------
    // Operands of the final subtraction, either straight from the tables or
    // from the optional lookup register stage.
    // -----------------------------------------------------------------------
    logic [15:0] sub_s;
    logic [13:0] sub_d;
    logic        sub_vld;

`ifdef IB_MUL_8X8_QS_PIPE_EN
    logic [15:0] qs_s_d, qs_s_q;
    logic [13:0] qs_d_d, qs_d_q;
    logic        pvld_d, pvld_q;

    // Lookup stage only loads on a valid pair; the valid bit always advances
    // so the output strobe stays aligned with the data.
    always_comb begin
        qs_s_d = qs_s_q;
        qs_d_d = qs_d_q;
        pvld_d = i_vld;
        if (i_vld) begin
            qs_s_d = qs_s;
            qs_d_d = qs_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            qs_s_q <= '0;
            qs_d_q <= '0;
            pvld_q <= 1'b0;
        end else begin
            qs_s_q <= qs_s_d;
            qs_d_q <= qs_d_d;
            pvld_q <= pvld_d;
        end
    end

    always_comb begin
        sub_s   = qs_s_q;
        sub_d   = qs_d_q;
        sub_vld = pvld_q;
    end
`else
    always_comb begin
        sub_s   = qs_s;
        sub_d   = qs_d;
        sub_vld = i_vld;
    end
`endif

    // -----------------------------------------------------------------------
    // Output register. The subtraction never underflows (sum >= diff), and
    // the result tops out at 65025.
    // -----------------------------------------------------------------------
    logic [15:0] prod;
    logic [15:0] o_c_d, o_c_q;
    logic        o_vld_d, o_vld_q;

    always_comb begin
        prod    = sub_s - {2'b00, sub_d};
        o_c_d   = o_c_q;
        o_vld_d = sub_vld;
        if (sub_vld) begin
            o_c_d = prod;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            o_c_q   <= '0;
            o_vld_q <= 1'b0;
        end else begin
            o_c_q   <= o_c_d;
            o_vld_q <= o_vld_d;
        end
    end

    assign o_c   = o_c_q;
    assign o_vld = o_vld_q;

endmodule

// File: tb/tb_ib_mul_8x8_qs.sv
// ---------------------------------------------------------------------------
// tb_ib_mul_8x8_qs
//   Randomised and directed stimulus against a behavioural model: each
//   accepted pair is queued as {valid, a*b} and emerges LAT edges later,
//   updating the expected output (o_c holds when the emerging slot is idle).
//   Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_ib_mul_8x8_qs;

`ifdef IB_MUL_8X8_QS_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        nrst;
    logic        vld;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        o_vld;
    logic [15:0] o_c;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    logic [16:0] pend [$];
    logic [15:0] exp_c;
    logic        exp_v;

    ib_mul_8x8_qs dut (
        .i_clk  (clk),
        .i_nrst (nrst),
        .i_vld  (vld),
        .i_a    (a),
        .i_b    (b),
        .o_vld  (o_vld),
        .o_c    (o_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one pair (called at a falling edge), advance the model at the
    // rising edge, return at the next falling edge.
    task automatic cyc(input logic v, input logic [7:0] av, input logic [7:0] bv);
        int          p;
        logic [16:0] e;
        vld = v;
        a   = av;
        b   = bv;
        p   = int'(av) * int'(bv);
        @(posedge clk);
        if (nrst) begin
            pend.push_back({v, 16'(p)});
            if (pend.size() >= LAT) begin
                e = pend.pop_front();
                if (e[16]) begin
                    exp_c = e[15:0];
                    exp_v = 1'b1;
                end else begin
                    exp_v = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        pend.delete();
        exp_c = '0;
        exp_v = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        vld  = 1'b1;
        a    = 8'hFF;
        b    = 8'hFF;
        model_reset();
        #2;
        n_tests++;
        if (o_c !== 16'h0000 || o_vld !== 1'b0)
            begin n_fail++; $display("FAIL reset_immediate: o_c=%h o_vld=%b want 0000/0", o_c, o_vld); end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'hFF, 8'hFF);
            n_tests++;
            if (o_c !== 16'h0000 || o_vld !== 1'b0)
                begin n_fail++; $display("FAIL reset_hold: o_c=%h o_vld=%b want 0000/0", o_c, o_vld); end
        end
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 8'hFF, 8'hFF);
            n_tests++;
            if (o_c !== 16'h0000 || o_vld !== 1'b0)
                begin n_fail++; $display("FAIL reset_release: o_c=%h o_vld=%b want 0000/0", o_c, o_vld); end
        end
    endtask

    task automatic test_corners();
        logic [7:0]  ca [5] = '{8'd0, 8'd255, 8'd1,   8'd128, 8'd255};
        logic [7:0]  cb [5] = '{8'd0, 8'd255, 8'd255, 8'd2,   8'd0};
        logic [15:0] cw [5] = '{16'd0, 16'd65025, 16'd255, 16'd256, 16'd0};
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, ca[i], cb[i]);
            for (int j = 1; j < LAT; j++) cyc(1'b0, 8'h00, 8'h00);
            n_tests++;
            if (o_c !== cw[i] || o_vld !== 1'b1 || exp_c !== cw[i])
                begin n_fail++; $display("FAIL corner_%0d: %0d*%0d o_c=%0d o_vld=%b want %0d/1", i, ca[i], cb[i], o_c, o_vld, cw[i]); end
            cyc(1'b0, 8'h00, 8'h00);
            n_tests++;
            if (o_c !== cw[i] || o_vld !== 1'b0)
                begin n_fail++; $display("FAIL corner_hold_%0d: o_c=%0d o_vld=%b want %0d/0", i, o_c, o_vld, cw[i]); end
        end
    endtask

    task automatic test_exhaustive();
        int bad = 0;
        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 0; ib < 256; ib++) begin
                cyc(1'b1, 8'(ia), 8'(ib));
                n_tests++;
                if (o_c !== exp_c || o_vld !== exp_v) begin
                    n_fail++;
                    if (bad < 10)
                        $display("FAIL exhaustive: a=%0d b=%0d o_c=%0d o_vld=%b want %0d/%b", ia, ib, o_c, o_vld, exp_c, exp_v);
                    bad++;
                end
            end
        end
        for (int j = 0; j < LAT; j++) begin
            cyc(1'b0, 8'h00, 8'h00);
            n_tests++;
            if (o_c !== exp_c || o_vld !== exp_v)
                begin n_fail++; $display("FAIL exhaustive_drain: o_c=%0d o_vld=%b want %0d/%b", o_c, o_vld, exp_c, exp_v); end
        end
        n_tests++;
        if (o_c !== 16'd65025)
            begin n_fail++; $display("FAIL exhaustive_last: o_c=%0d want 65025", o_c); end
    endtask

    task automatic test_valid_gating();
        logic        sv [3] = '{1'b1, 1'b0, 1'b1};
        logic [7:0]  sa [3] = '{8'd3, 8'd9, 8'd7};
        logic [7:0]  sb [3] = '{8'd5, 8'd9, 8'd11};
        logic [15:0] wc [3] = '{16'd15, 16'd15, 16'd77};
        logic        wv [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3 + LAT - 1; i++) begin
            if (i < 3) cyc(sv[i], sa[i], sb[i]);
            else       cyc(1'b0, 8'd0, 8'd0);
            if (i >= LAT - 1) begin
                n_tests++;
                if (o_c !== wc[i-LAT+1] || o_vld !== wv[i-LAT+1])
                    begin n_fail++; $display("FAIL valid_gating_%0d: o_c=%0d o_vld=%b want %0d/%b", i-LAT+1, o_c, o_vld, wc[i-LAT+1], wv[i-LAT+1]); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'd200, 8'd200);
        n_tests++;
        if (o_c !== 16'd40000 || o_vld !== 1'b1)
            begin n_fail++; $display("FAIL midstream_pre: o_c=%0d o_vld=%b want 40000/1", o_c, o_vld); end
        nrst = 1'b0;
        #1;
        n_tests++;
        if (o_c !== 16'h0000 || o_vld !== 1'b0)
            begin n_fail++; $display("FAIL midstream_reset: o_c=%0d o_vld=%b want 0/0", o_c, o_vld); end
        #1;
        nrst = 1'b1;
        model_reset();
        @(negedge clk);
        cyc(1'b1, 8'd13, 8'd19);
        for (int j = 1; j < LAT; j++) begin
            n_tests++;
            if (o_c !== 16'h0000 || o_vld !== 1'b0)
                begin n_fail++; $display("FAIL midstream_flush: o_c=%0d o_vld=%b want 0/0", o_c, o_vld); end
            cyc(1'b0, 8'd0, 8'd0);
        end
        n_tests++;
        if (o_c !== 16'd247 || o_vld !== 1'b1)
            begin n_fail++; $display("FAIL midstream_next: o_c=%0d o_vld=%b want 247/1", o_c, o_vld); end
    endtask

    task automatic test_symmetry();
        logic [7:0]  sa [3] = '{8'd17, 8'd4,  8'd254};
        logic [7:0]  sb [3] = '{8'd4,  8'd17, 8'd1};
        logic [15:0] wc [3] = '{16'd68, 16'd68, 16'd254};
        for (int i = 0; i < 3 + LAT - 1; i++) begin
            if (i < 3) cyc(1'b1, sa[i], sb[i]);
            else       cyc(1'b0, 8'd0, 8'd0);
            if (i >= LAT - 1) begin
                n_tests++;
                if (o_c !== wc[i-LAT+1] || o_vld !== 1'b1)
                    begin n_fail++; $display("FAIL symmetry_%0d: o_c=%0d o_vld=%b want %0d/1", i-LAT+1, o_c, o_vld, wc[i-LAT+1]); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
            n_tests++;
            if (o_c !== exp_c || o_vld !== exp_v)
                begin n_fail++; $display("FAIL random_%0d: o_c=%0d o_vld=%b want %0d/%b", i, o_c, o_vld, exp_c, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_valid_gating();
        test_symmetry();
        test_reset_midstream();
        test_random();
        test_exhaustive();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
